// File: rtl/hdmi_clock_sequencer.sv
// Lock-qualified reset sequencer and serializer phase generator for the HDMI TX path.
// All logic runs on the fast serial clock; outputs decode from registered state only.
module hdmi_clock_sequencer #(
    parameter int DIV_RATIO          = 5,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int SYNC_STAGES        = 2,
    parameter int LOSS_CNT_W         = 8,
    localparam int PW                = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  force_resync,
    output logic                  domain_rst,
    output logic                  ready,
    output logic                  load_stb,
    output logic [PW-1:0]         phase,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_STABLE    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int SCW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int HCW = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [SCW-1:0] STABLE_LAST = SCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LAST   = HCW'(RST_HOLD_CYCLES - 1);
    localparam logic [PW-1:0]  PHASE_LAST  = PW'(DIV_RATIO - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [SCW-1:0]         stable_cnt_q, stable_cnt_d;
    logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [PW-1:0]          phase_q, phase_d;
    logic [LOSS_CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
    logic                   lock_sync;
    logic [PW-1:0]          phase_inc;

    assign lock_sync = sync_q[SYNC_STAGES-1];
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], pll_lock};
    assign phase_inc = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);

    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        phase_d      = phase_q;
        loss_cnt_d   = loss_cnt_q;

        if (force_resync) begin
            // Resync wins over everything, including a coincident lock loss.
            state_d      = ST_WAIT_LOCK;
            stable_cnt_d = '0;
            hold_cnt_d   = '0;
            phase_d      = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    stable_cnt_d = '0;
                    hold_cnt_d   = '0;
                    phase_d      = '0;
                    if (lock_sync) begin
                        state_d = ST_STABLE;
                    end
                end
                ST_STABLE: begin
                    phase_d = '0;
                    if (!lock_sync) begin
                        state_d      = ST_WAIT_LOCK;
                        stable_cnt_d = '0;
                    end else if (stable_cnt_q == STABLE_LAST) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        stable_cnt_d = stable_cnt_q + SCW'(1);
                    end
                end
                ST_HOLD: begin
                    if (!lock_sync) begin
                        state_d      = ST_WAIT_LOCK;
                        stable_cnt_d = '0;
                        hold_cnt_d   = '0;
                        phase_d      = '0;
                    end else begin
                        phase_d = phase_inc;
                        if (hold_cnt_q != HOLD_LAST) begin
                            hold_cnt_d = hold_cnt_q + HCW'(1);
                        end
                        // Release only on a phase wrap so RUN starts on phase 0.
                        if (hold_cnt_q == HOLD_LAST && phase_q == PHASE_LAST) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    if (!lock_sync) begin
                        state_d      = ST_WAIT_LOCK;
                        stable_cnt_d = '0;
                        hold_cnt_d   = '0;
                        phase_d      = '0;
                        if (loss_cnt_q != '1) begin
                            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
                        end
                    end else begin
                        phase_d = phase_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            state_q      <= ST_WAIT_LOCK;
            stable_cnt_q <= '0;
            hold_cnt_q   <= '0;
            phase_q      <= '0;
            loss_cnt_q   <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            phase_q      <= phase_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    assign state         = state_q;
    assign ready         = (state_q == ST_RUN);
    assign domain_rst    = (state_q != ST_RUN);
    assign load_stb      = (state_q == ST_RUN) && (phase_q == '0);
    assign phase         = phase_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_hdmi_clock_sequencer.sv
// Directed bench for hdmi_clock_sequencer: three configurations share one stimulus stream.
module tb_hdmi_clock_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic pll_lock;
    logic force_resync;

    logic       a_domain_rst, a_ready, a_load_stb;
    logic [2:0] a_phase;
    logic [7:0] a_loss;
    logic [1:0] a_state;

    logic       s_domain_rst, s_ready, s_load_stb;
    logic [2:0] s_phase;
    logic [1:0] s_loss;
    logic [1:0] s_state;

    logic       d_domain_rst, d_ready, d_load_stb;
    logic [3:0] d_phase;
    logic [7:0] d_loss;
    logic [1:0] d_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hdmi_clock_sequencer #(
        .DIV_RATIO(5), .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(16),
        .SYNC_STAGES(2), .LOSS_CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .force_resync(force_resync),
        .domain_rst(a_domain_rst), .ready(a_ready), .load_stb(a_load_stb),
        .phase(a_phase), .lock_loss_cnt(a_loss), .state(a_state)
    );

    hdmi_clock_sequencer #(
        .DIV_RATIO(5), .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(16),
        .SYNC_STAGES(2), .LOSS_CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .force_resync(force_resync),
        .domain_rst(s_domain_rst), .ready(s_ready), .load_stb(s_load_stb),
        .phase(s_phase), .lock_loss_cnt(s_loss), .state(s_state)
    );

    hdmi_clock_sequencer #(
        .DIV_RATIO(10), .LOCK_STABLE_CYCLES(8), .RST_HOLD_CYCLES(3),
        .SYNC_STAGES(2), .LOSS_CNT_W(8)
    ) u_d10 (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .force_resync(force_resync),
        .domain_rst(d_domain_rst), .ready(d_ready), .load_stb(d_load_stb),
        .phase(d_phase), .lock_loss_cnt(d_loss), .state(d_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then land on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        pll_lock     = 1'b0;
        force_resync = 1'b0;
        @(negedge clk);

        // Reset state held over three cycles
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_domain_rst", a_domain_rst, 1);
            check("rst_ready", a_ready, 0);
            check("rst_state", a_state, 0);
            check("rst_loss", a_loss, 0);
            check("rst_phase", a_phase, 0);
            check("rst_load_stb", a_load_stb, 0);
        end
        rst = 1'b0;
        step(2);
        check("idle_state", a_state, 0);

        // Lock-up latency with DIV_RATIO=5
        pll_lock = 1'b1;
        step(2);
        check("pre_stable_state", a_state, 0);
        step(1);
        check("stable_state", a_state, 1);
        check("stable_phase", a_phase, 0);
        step(7);
        check("stable_last", a_state, 1);
        step(1);
        check("hold_state", a_state, 2);
        check("hold_entry_phase", a_phase, 0);
        check("hold_domain_rst", a_domain_rst, 1);
        step(19);
        check("hold_last_state", a_state, 2);
        check("hold_last_phase", a_phase, 4);
        step(1);
        check("run_state", a_state, 3);
        check("run_phase0", a_phase, 0);
        check("run_load0", a_load_stb, 1);
        check("run_ready", a_ready, 1);
        check("run_domain_rst", a_domain_rst, 0);
        for (int i = 1; i < 12; i++) begin
            step(1);
            check("run_phase", a_phase, i % 5);
            check("run_load", a_load_stb, (i % 5) == 0);
        end

        // Lock losses in RUN; u_sat saturates at 3
        for (int k = 1; k <= 5; k++) begin
            pll_lock = 1'b0;
            step(2);
            check("drop_still_run", a_domain_rst, 0);
            step(1);
            check("drop_domain_rst", a_domain_rst, 1);
            check("drop_ready", a_ready, 0);
            check("drop_state", a_state, 0);
            check("drop_phase", a_phase, 0);
            check("loss_cnt", a_loss, k);
            check("loss_cnt_sat", s_loss, (k > 3) ? 3 : k);
            step(2);
            check("loss_no_repeat", a_loss, k);
            pll_lock = 1'b1;
            step(31);
            check("relock_ready", a_ready, 1);
            check("relock_load", a_load_stb, 1);
        end

        // force_resync coincident with lock_sync falling
        pll_lock = 1'b0;
        step(2);
        force_resync = 1'b1;
        step(1);
        force_resync = 1'b0;
        check("resync_state", a_state, 0);
        check("resync_loss", a_loss, 5);
        check("resync_loss_sat", s_loss, 3);
        check("resync_phase", a_phase, 0);
        step(3);
        check("resync_loss_later", a_loss, 5);

        // force_resync from RUN with lock present restarts the full sequence
        pll_lock = 1'b1;
        step(31);
        check("prefr_run", a_state, 3);
        force_resync = 1'b1;
        step(1);
        force_resync = 1'b0;
        check("fr_state", a_state, 0);
        check("fr_loss", a_loss, 5);
        step(1);
        check("fr_stable", a_state, 1);
        step(8);
        check("fr_hold", a_state, 2);
        step(20);
        check("fr_run", a_state, 3);

        // Mid-sequence reset clears the loss counter
        rst      = 1'b1;
        pll_lock = 1'b0;
        step(1);
        check("midrst_state", a_state, 0);
        check("midrst_loss", a_loss, 0);
        check("midrst_domain_rst", a_domain_rst, 1);
        check("midrst_phase", a_phase, 0);
        step(1);
        rst = 1'b0;
        step(1);

        // Lock drop during STABLE restarts the stable count
        pll_lock = 1'b1;
        step(3);
        check("s3_stable", a_state, 1);
        step(5);
        pll_lock = 1'b0;
        step(2);
        check("s3_still_stable", a_state, 1);
        step(1);
        check("s3_back_wait", a_state, 0);
        step(1);
        pll_lock = 1'b1;
        step(2);
        check("s3_wait_sync", a_state, 0);
        step(1);
        check("s3_restable", a_state, 1);
        step(7);
        check("s3_stable_full", a_state, 1);
        step(1);
        check("s3_hold", a_state, 2);
        step(20);
        check("s3_run", a_state, 3);
        check("s3_load", a_load_stb, 1);
        check("s3_loss", a_loss, 0);

        // DIV_RATIO=10, RST_HOLD_CYCLES=3
        rst      = 1'b1;
        pll_lock = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(3);
        check("d10_stable", d_state, 1);
        step(8);
        check("d10_hold", d_state, 2);
        check("d10_hold_phase0", d_phase, 0);
        for (int i = 1; i < 10; i++) begin
            step(1);
            check("d10_hold_phase", d_phase, i);
            check("d10_hold_state", d_state, 2);
        end
        step(1);
        check("d10_run", d_state, 3);
        check("d10_run_phase0", d_phase, 0);
        check("d10_run_load0", d_load_stb, 1);
        for (int i = 1; i < 21; i++) begin
            step(1);
            check("d10_run_phase", d_phase, i % 10);
            check("d10_run_load", d_load_stb, (i % 10) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
